// File: rtl/pulse2lvl_pkg.sv
// Shared definitions for the pulse-to-level stretcher.
// State codes match the lvl->pulse converter's encoding.
package pulse2lvl_pkg;

    typedef enum logic [1:0] {
        P2L_IDLE = 2'b00,
        P2L_HOLD = 2'b01,
        P2L_GAP  = 2'b11
    } p2l_state_t;

    function automatic int p2l_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse2lvl_downcnt.sv
// Loadable down counter shared by the HOLD and GAP phases.
// Saturates at zero; a load always wins over a decrement.
module pulse2lvl_downcnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: load, else decrement without wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse2lvl.sv
// Stretches a one-cycle pulse into a level of HOLD_CYCLES cycles,
// followed by a forced low gap; ignored pulses are flagged on dropped.
module pulse2lvl
    import pulse2lvl_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter bit RETRIGGER   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse,
    input  logic clear,
    output logic lvl,
    output logic busy,
    output logic dropped
);

    localparam int CNT_W = $clog2(p2l_max(p2l_max(HOLD_CYCLES, GAP_CYCLES), 1) + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    p2l_state_t       state;
    p2l_state_t       state_n;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dec;
    logic             zero;
    logic             drop_n;
    logic             lvl_n;
    logic             busy_n;
    logic             reload_ok;

    pulse2lvl_downcnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // With no gap, a pulse on the final hold cycle simply extends the level.
    assign reload_ok = RETRIGGER || ((GAP_CYCLES == 0) && zero);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= P2L_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter control and drop detection.
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        drop_n   = 1'b0;
        if (clear) begin
            state_n = P2L_IDLE;
            load    = 1'b1;
            drop_n  = pulse;
        end else begin
            unique case (state)
                P2L_IDLE: begin
                    if (pulse) begin
                        state_n  = P2L_HOLD;
                        load     = 1'b1;
                        load_val = HOLD_LD;
                    end
                end
                P2L_HOLD: begin
                    if (pulse && reload_ok) begin
                        load     = 1'b1;
                        load_val = HOLD_LD;
                    end else begin
                        drop_n = pulse;
                        if (!zero) begin
                            dec = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_n = P2L_IDLE;
                        end else begin
                            state_n  = P2L_GAP;
                            load     = 1'b1;
                            load_val = GAP_LD;
                        end
                    end
                end
                P2L_GAP: begin
                    drop_n = pulse;
                    if (zero) begin
                        state_n = P2L_IDLE;
                    end else begin
                        dec = 1'b1;
                    end
                end
                default: begin
                    state_n = P2L_IDLE;
                    load    = 1'b1;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        lvl_n  = (state_n == P2L_HOLD);
        busy_n = (state_n != P2L_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl     <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            lvl     <= lvl_n;
            busy    <= busy_n;
            dropped <= drop_n;
        end
    end

endmodule

// File: tb/tb_pulse2lvl.sv
// Directed bench for pulse2lvl: three instances cover retrigger,
// no-retrigger and zero-gap variants driven by the same stimulus.
module tb_pulse2lvl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pulse = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] lvl_v;
    logic [2:0] busy_v;
    logic [2:0] drop_v;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pulse2lvl #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1)) u_a (
        .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
        .lvl(lvl_v[0]), .busy(busy_v[0]), .dropped(drop_v[0])
    );

    pulse2lvl #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b0)) u_b (
        .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
        .lvl(lvl_v[1]), .busy(busy_v[1]), .dropped(drop_v[1])
    );

    pulse2lvl #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(1'b0)) u_c (
        .clk(clk), .reset(reset), .pulse(pulse), .clear(clear),
        .lvl(lvl_v[2]), .busy(busy_v[2]), .dropped(drop_v[2])
    );

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bit1(input int b);
        logic [31:0] m;
        m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        pulse = 1'b0;
        clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive cycles 0..29; output expectations are indexed by cycle number.
    task automatic run_case(input string name, input int d,
                            input logic [31:0] pm, input logic [31:0] cm,
                            input logic [31:0] el, input logic [31:0] eb,
                            input logic [31:0] ed);
        do_reset();
        for (int c = 0; c < 30; c++) begin
            pulse = pm[c];
            clear = cm[c];
            @(posedge clk);
            #1;
            chk($sformatf("%s lvl c%0d", name, c + 1), lvl_v[d], el[c + 1]);
            chk($sformatf("%s busy c%0d", name, c + 1), busy_v[d], eb[c + 1]);
            chk($sformatf("%s drop c%0d", name, c + 1), drop_v[d], ed[c + 1]);
        end
        pulse = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        do_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst lvl d%0d", d), lvl_v[d], 1'b0);
            chk($sformatf("rst busy d%0d", d), busy_v[d], 1'b0);
            chk($sformatf("rst drop d%0d", d), drop_v[d], 1'b0);
        end

        run_case("single", 0, bit1(10), '0,
                 rng(11, 14), rng(11, 16), '0);
        run_case("single_nr", 1, bit1(10), '0,
                 rng(11, 14), rng(11, 16), '0);
        run_case("retrig", 0, bit1(10) | bit1(12), '0,
                 rng(11, 16), rng(11, 18), '0);
        run_case("noretrig", 1, bit1(10) | bit1(12), '0,
                 rng(11, 14), rng(11, 16), bit1(13));
        run_case("gap_drop", 0, bit1(10) | bit1(15) | bit1(17), '0,
                 rng(11, 14) | rng(18, 21), rng(11, 16) | rng(18, 23),
                 bit1(16));
        run_case("gap_last", 0, bit1(10) | bit1(16), '0,
                 rng(11, 14), rng(11, 16), bit1(17));
        run_case("nogap", 2, bit1(10) | bit1(14), '0,
                 rng(11, 18), rng(11, 18), '0);
        run_case("nogap_mid", 2, bit1(10) | bit1(12), '0,
                 rng(11, 14), rng(11, 14), bit1(13));
        run_case("clear", 0, bit1(10) | bit1(12), bit1(12),
                 rng(11, 12), rng(11, 12), bit1(13));

        // Asynchronous reset in the middle of a hold, then recovery.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            pulse = (c == 10);
            @(posedge clk);
            #1;
        end
        pulse = 1'b0;
        chk("pre_rst lvl", lvl_v[0], 1'b1);
        #4 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("arst lvl d%0d", d), lvl_v[d], 1'b0);
            chk($sformatf("arst busy d%0d", d), busy_v[d], 1'b0);
            chk($sformatf("arst drop d%0d", d), drop_v[d], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 pulse = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
        chk("post_rst lvl", lvl_v[0], 1'b1);
        chk("post_rst busy", busy_v[0], 1'b1);
        chk("post_rst drop", drop_v[0], 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst gap lvl", lvl_v[0], 1'b0);
        chk("post_rst gap busy", busy_v[0], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
